// File: rtl/mips16_trace_capture_if.sv
// Trace stream interface between the trace capture block and its consumer.
//   trace_valid - head entry available (producer -> consumer)
//   trace_ready - consumer accepts the head entry (consumer -> producer)
//   trace_pc    - head entry program-counter field
//   trace_data  - head entry alu_result field
interface mips16_trace_capture_if #(
   parameter int DATA_W = 16
);
   logic              trace_valid;
   logic              trace_ready;
   logic [DATA_W-1:0] trace_pc;
   logic [DATA_W-1:0] trace_data;

   modport master (output trace_valid, trace_pc, trace_data, input  trace_ready);
   modport slave  (input  trace_valid, trace_pc, trace_data, output trace_ready);
endinterface

// File: rtl/mips16_trace_capture.sv
// Passive trace sink for the mips_16 core. Every time the observed program
// counter takes a new value (while cap_en is high) the {pc, alu_result} pair is
// pushed into a small FIFO, which drains over a valid/ready stream.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   cap_en          - level-sensitive capture enable
//   clear           - synchronous one-cycle flush (wins over push/pop)
//   pc_in, alu_in   - observed core outputs
//   trace           - stream master (trace_valid/ready/pc/data)
//   count           - occupancy, 0..DEPTH
//   overflow        - sticky, set when a capture was dropped on a full FIFO
//   drop_cnt        - saturating count of dropped captures
module mips16_trace_capture #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int DROP_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cap_en,
   input  logic                   clear,
   input  logic [DATA_W-1:0]      pc_in,
   input  logic [DATA_W-1:0]      alu_in,
   mips16_trace_capture_if.master trace,
   output logic [ADDR_W:0]        count,
   output logic                   overflow,
   output logic [DROP_W-1:0]      drop_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] alu;
   } entry_t;

   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

   entry_t            mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr, rd_ptr;   // extra MSB tells full from empty
   logic [DATA_W-1:0] prev_pc;
   logic              seen;
   entry_t            head, head_nxt;

   logic              empty, full, capture, pop, push, drop;
   logic [ADDR_W-1:0] rd_nxt_idx;
   entry_t            new_entry;

   assign count      = wr_ptr - rd_ptr;
   assign empty      = (count == '0);
   assign full       = (count == CNT_FULL);
   assign capture    = cap_en && (!seen || pc_in != prev_pc);
   assign pop        = !empty && trace.trace_ready;
   // A full FIFO still accepts a capture when the head leaves on the same edge.
   assign push       = capture && (!full || pop);
   assign drop       = capture && full && !pop;
   assign rd_nxt_idx = rd_ptr[ADDR_W-1:0] + 1'b1;
   assign new_entry  = '{pc: pc_in, alu: alu_in};

   // trace_valid is decoded from the pointers only, so trace_ready never
   // reaches it combinationally.
   assign trace.trace_valid = !empty;
   assign trace.trace_pc    = head.pc;
   assign trace.trace_data  = head.alu;

   // Show-ahead head register: it holds the entry the next pop would deliver,
   // and keeps the last popped pair once the FIFO runs dry.
   always_comb begin
      // NOTE: default first so every path assigns head_nxt and no latch is inferred.
      head_nxt = head;
      if (pop) begin
         if (count != CNT_ONE) head_nxt = mem[rd_nxt_idx];
         else if (push)        head_nxt = new_entry;  // single entry replaced by the incoming one
      end else if (empty && push) begin
         head_nxt = new_entry;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         prev_pc  <= '0;
         seen     <= 1'b0;
         overflow <= 1'b0;
         drop_cnt <= '0;
         head     <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         seen     <= 1'b0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         head <= head_nxt;
         if (capture) begin
            prev_pc <= pc_in;
            seen    <= 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which
   // slots are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr[ADDR_W-1:0]] <= new_entry;
   end

endmodule

// File: tb/tb_mips16_trace_capture.sv
// Directed bench for mips16_trace_capture with a queue-based reference model
// and a negedge compare process, plus literal expectations per scenario.
module tb_mips16_trace_capture;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int DROP_W = 8;

   logic              clk;
   logic              reset;
   logic              cap_en;
   logic              clear;
   logic [DATA_W-1:0] pc_in;
   logic [DATA_W-1:0] alu_in;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;

   mips16_trace_capture_if #(.DATA_W(DATA_W)) tif ();

   mips16_trace_capture #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_W(DROP_W)
   ) dut (
      .clk(clk), .reset(reset), .cap_en(cap_en), .clear(clear),
      .pc_in(pc_in), .alu_in(alu_in), .trace(tif),
      .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a queue of {pc, alu} pairs updated from the sampled inputs.
   logic [31:0]       q [$];
   logic [DATA_W-1:0] m_prev;
   bit                m_seen;
   bit                m_ov;
   int                m_drops;
   logic [31:0]       m_last;
   bit                m_head_known;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         m_prev = '0; m_seen = 0; m_ov = 0; m_drops = 0;
         m_last = '0; m_head_known = 1;
      end else if (clear) begin
         q.delete();
         m_seen = 0; m_ov = 0; m_drops = 0;
         m_head_known = 0;  // head contents after a flush are not defined
      end else begin
         bit do_pop, do_cap;
         do_pop = (q.size() > 0) && tif.trace_ready;
         do_cap = cap_en && (!m_seen || pc_in != m_prev);
         if (do_pop) begin
            m_last = q.pop_front();
            m_head_known = 1;
         end
         if (do_cap) begin
            m_prev = pc_in;
            m_seen = 1;
            if (q.size() < DEPTH) q.push_back({pc_in, alu_in});
            else begin
               m_ov = 1;
               if (m_drops < 255) m_drops++;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] e;
      check("cmp_valid", 32'(tif.trace_valid), 32'(q.size() != 0));
      check("cmp_count", 32'(count), 32'(q.size()));
      check("cmp_overflow", 32'(overflow), 32'(m_ov));
      check("cmp_drop_cnt", 32'(drop_cnt), 32'(m_drops));
      if (q.size() != 0) e = q[0];
      else               e = m_last;
      if (q.size() != 0 || m_head_known) begin
         check("cmp_head_pc", 32'(tif.trace_pc), 32'(e[31:16]));
         check("cmp_head_data", 32'(tif.trace_data), 32'(e[15:0]));
      end
   end

   // One clock: apply inputs at a negedge, return at the next negedge.
   task automatic cyc(input logic [15:0] pc, input logic [15:0] alu,
                      input logic en, input logic rdy, input logic clr);
      pc_in = pc; alu_in = alu; cap_en = en; tif.trace_ready = rdy; clear = clr;
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc(pc_in, alu_in, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      reset = 1'b1; cap_en = 1'b0; clear = 1'b0; pc_in = '0; alu_in = '0;
      tif.trace_ready = 1'b0;
      @(negedge clk);
      check("reset_valid", 32'(tif.trace_valid), 32'h0);
      check("reset_count", 32'(count), 32'h0);
      check("reset_pc", 32'(tif.trace_pc), 32'h0);
      check("reset_data", 32'(tif.trace_data), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Three stepping pcs, no consumer.
      cyc(16'h0000, 16'h0011, 1, 0, 0);
      check("t1_valid_latency", 32'(tif.trace_valid), 32'h1);
      cyc(16'h0002, 16'h0022, 1, 0, 0);
      cyc(16'h0004, 16'h0033, 1, 0, 0);
      check("t1_count", 32'(count), 32'd3);
      check("t1_head_pc", 32'(tif.trace_pc), 32'h0000);
      check("t1_head_data", 32'(tif.trace_data), 32'h0011);
      drain(3);
      check("t1_drained", 32'(count), 32'd0);
      check("t1_hold_pc", 32'(tif.trace_pc), 32'h0004);
      check("t1_hold_data", 32'(tif.trace_data), 32'h0033);

      // Held pc captured once, then a change captured.
      for (int i = 0; i < 5; i++) cyc(16'h0008, 16'h0080 + 16'(i), 1, 0, 0);
      check("t2_held_once", 32'(count), 32'd1);
      check("t2_first_alu", 32'(tif.trace_data), 32'h0080);
      cyc(16'h000A, 16'h00A0, 1, 0, 0);
      check("t2_second", 32'(count), 32'd2);
      drain(2);

      // Ten distinct pcs into eight slots.
      for (int i = 0; i < 10; i++) cyc(16'h0020 + 16'(2*i), 16'h0100 + 16'(i), 1, 0, 0);
      check("t3_count", 32'(count), 32'd8);
      check("t3_overflow", 32'(overflow), 32'h1);
      check("t3_drop_cnt", 32'(drop_cnt), 32'd2);
      for (int i = 0; i < 8; i++) begin
         check("t3_order_pc", 32'(tif.trace_pc), 32'h0020 + 32'(2*i));
         check("t3_order_data", 32'(tif.trace_data), 32'h0100 + 32'(i));
         drain(1);
      end
      check("t3_empty", 32'(tif.trace_valid), 32'h0);

      // Full FIFO: pop and push on the same edge.
      for (int i = 0; i < 8; i++) cyc(16'h0040 + 16'(2*i), 16'h0200 + 16'(i), 1, 0, 0);
      cyc(16'h0100, 16'hABCD, 1, 1, 0);
      check("t4_count_stays", 32'(count), 32'd8);
      check("t4_no_drop", 32'(drop_cnt), 32'd2);
      for (int i = 0; i < 8; i++) begin
         check("t4_order_pc", 32'(tif.trace_pc), (i < 7) ? 32'h0042 + 32'(2*i) : 32'h0100);
         check("t4_order_data", 32'(tif.trace_data), (i < 7) ? 32'h0201 + 32'(i) : 32'hABCD);
         drain(1);
      end

      // Asynchronous reset mid-cycle with four entries queued.
      for (int i = 0; i < 4; i++) cyc(16'h0060 + 16'(2*i), 16'h0300 + 16'(i), 1, 0, 0);
      check("t5_queued", 32'(count), 32'd4);
      cap_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("t5_async_valid", 32'(tif.trace_valid), 32'h0);
      check("t5_async_count", 32'(count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cyc(16'h0000, 16'h0077, 1, 0, 0);
      check("t5_first_after", 32'(count), 32'd1);
      check("t5_first_pc", 32'(tif.trace_pc), 32'h0000);
      check("t5_first_data", 32'(tif.trace_data), 32'h0077);
      drain(1);

      // Clear with a same-edge capture while overflowed.
      for (int i = 0; i < 10; i++) cyc(16'h0080 + 16'(2*i), 16'h0400 + 16'(i), 1, 0, 0);
      drain(5);
      check("t6_count3", 32'(count), 32'd3);
      check("t6_ov_set", 32'(overflow), 32'h1);
      cyc(16'h0300, 16'h0055, 1, 0, 1);
      check("t6_clr_count", 32'(count), 32'd0);
      check("t6_clr_ov", 32'(overflow), 32'h0);
      check("t6_clr_drop", 32'(drop_cnt), 32'd0);
      check("t6_clr_valid", 32'(tif.trace_valid), 32'h0);
      cyc(16'h0302, 16'h0066, 1, 0, 0);
      check("t6_next_count", 32'(count), 32'd1);
      check("t6_next_pc", 32'(tif.trace_pc), 32'h0302);
      check("t6_next_data", 32'(tif.trace_data), 32'h0066);
      cyc(16'h0302, 16'h0066, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
